// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter/sequencer with fixed wait-state strobes and registered outputs.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_OUT,
  output logic              SRAM_DQ_OE,
  input  logic [DATA_W-1:0] SRAM_DQ_IN,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              win;
  logic              sel_we;

`ifdef MEM_ARB_RR_EN
  logic              prio_q, prio_d;
  // prio_q names the port that wins the next tie
  assign win = (req0 && req1) ? prio_q : req1;
`else
  assign win = !req0;
`endif

  assign sel_we = win ? we1 : we0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    own_d    = own_q;
    we_d     = we_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = dq_oe_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
`ifdef MEM_ARB_RR_EN
    prio_d   = prio_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = ACCESS;
          own_d    = win;
          we_d     = sel_we;
          addr_d   = win ? addr1 : addr0;
          dq_out_d = win ? wdata1 : wdata0;
          gnt0_d   = !win;
          gnt1_d   = win;
          cnt_d    = CNT_INIT;
          ce_n_d   = 1'b0;
          oe_n_d   = sel_we;
          we_n_d   = !sel_we;
          dq_oe_d  = sel_we;
`ifdef MEM_ARB_RR_EN
          prio_d   = !win;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          done0_d = !own_q;
          done1_d = own_q;
          if (!we_q) rdata_d = SRAM_DQ_IN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops strobes immediately, aborting any access in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
`ifdef MEM_ARB_RR_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      own_q    <= own_d;
      we_q     <= we_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
`ifdef MEM_ARB_RR_EN
      prio_q   <= prio_d;
`endif
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = dq_out_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared 16-bit SRAM. Port 0 is the CPU's memory path (MAR/MDR with the control unit's Mem_OE/Mem_WE requests); port 1 is a secondary master such as the program loader or a DMA/display reader. It grants one access at a time and drives the SRAM strobes with a fixed, parameterised wait-state count. It returns a one-cycle done pulse with registered read data.

## Interface
- ADDR_W, 20, SRAM address width
- DATA_W, 16, data width
- WAIT_CYCLES, 2, SRAM strobe cycles per access; legal range 1..15
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request, held until done
- we0, we1  in  1  1 = write, 0 = read; valid while req high
- addr0, addr1  in  ADDR_W  access address; stable while req high
- wdata0, wdata1  in  DATA_W  write data; stable while req high
- gnt0, gnt1  out  1  port owns the SRAM (ACCESS and DONE states)
- done0, done1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid in the done cycle, held until the next read completes
- SRAM_ADDR  out  ADDR_W  SRAM address
- SRAM_DQ_OUT  out  DATA_W  write data to pad tristate
- SRAM_DQ_OE  out  1  1 = drive the pads with SRAM_DQ_OUT
- SRAM_DQ_IN  in  DATA_W  pad read data
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1  active-low strobes

## Operation
- States: IDLE, ACCESS, DONE. Reset enters IDLE.
- IDLE: if any req is high at the clock edge, select a winner, register its we/addr/wdata and set its gnt, load wait counter = WAIT_CYCLES-1, then go to ACCESS. If no req is high, stay in IDLE.
- ACCESS: CE_N=0. For a read, OE_N=0. For a write, WE_N=0 and DQ_OE=1. Counter decrements each cycle. On the edge where the counter is 0, a read captures SRAM_DQ_IN into rdata, and the state goes to DONE.
- DONE: strobes inactive, SRAM_ADDR held, gnt held, done of the owning port = 1. The next state is always IDLE, and gnt clears there.
- Requester rule: drop req in the cycle done is seen. A req still high in IDLE is a new access.
- Arbitration: a winner is chosen only in IDLE and is never preempted. If only one port requests, it wins. Tie-break when both request is set by the Configuration section.
- Inputs are ignored outside IDLE, including changes to the non-granted port.
- Reset values: gnt*=0, done*=0, rdata=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SRAM_DQ_OE=0, all *_N=1, state IDLE, priority pointer = port 0.
- Reset mid-access: strobes deassert asynchronously, the access is aborted, no done is issued, and rdata is set to 0.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Timing
- req sampled at IDLE edge E0 → ACCESS for cycles 1..WAIT_CYCLES → done high in cycle WAIT_CYCLES+1 → IDLE in cycle WAIT_CYCLES+2.
- Total latency is WAIT_CYCLES+1 cycles to done.
- A back-to-back access from the same or the other port starts its sampling edge at the end of the IDLE cycle. Throughput is one access per WAIT_CYCLES+2 cycles.
- SRAM_ADDR is stable from the first ACCESS cycle through DONE.
- SRAM_DQ_OE is never 1 in the same cycle as OE_N=0.

## Configuration
- MEM_ARB_RR_EN defined: round-robin tie-break. When both ports request in IDLE, the port not granted most recently wins. The pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, port 0 (CPU) always wins ties. Port 1 can starve; this is acceptable for loader-only use while the CPU is halted.

## Test plan
- Read, port 0, WAIT_CYCLES=2, SRAM model returns 16'h1234 at addr 20'h00010: req0 → OE_N low cycles 1–2, done0 in cycle 3, rdata=16'h1234, gnt1 never high.
- Write, port 1, addr 20'h00020, wdata 16'hBEEF: WE_N low and DQ_OE=1 for 2 cycles, then done1. A subsequent port 0 read of 20'h00020 returns 16'hBEEF.
- Both req held continuously: with MEM_ARB_RR_EN, grants alternate 0,1,0,1 with done every 4 cycles. Without MEM_ARB_RR_EN, only port 0 is served while req0 stays high.
- req1 rises during a port 0 ACCESS: port 0 completes unaffected. Port 1 is granted at the next IDLE edge, and its done arrives 3 cycles after that edge.
- Reset asserted asynchronously in the second ACCESS cycle of a write: WE_N=1, DQ_OE=0 and gnt=0 before the next edge, and no done pulse. After release, a new req0 read completes normally.
- WAIT_CYCLES=1: read done arrives in cycle 2 with correct data. No cycle has both DQ_OE=1 and OE_N=0.
